// File: rtl/bin2bcd_16bit.sv
// 16-bit binary to 5-digit packed BCD converter using the shift-and-add-3 method.
// Optional macro BIN2BCD_AUTO_CONVERT_EN also starts a conversion when num changes while idle.
module bin2bcd_16bit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] num,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [19:0] bcd
);

   // Handshake: start is level-sampled only while busy=0; done pulses for one
   // cycle exactly when bcd takes a new value. busy and done are never both high.

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] shift_q, shift_d;
   logic [19:0] acc_q, acc_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [19:0] bcd_q, bcd_d;
   logic        done_q, done_d;
   logic        busy_q, busy_d;
   logic [19:0] adj;
   logic        go;

`ifdef BIN2BCD_AUTO_CONVERT_EN
   logic [15:0] last_q, last_d;
   assign go = start || (num != last_q);
`else
   assign go = start;
`endif

   // Per-digit 4-bit correction; no carry crosses a digit boundary.
   always_comb begin
      adj = acc_q;
      for (int i = 0; i < 5; i++) begin
         adj[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
`ifdef BIN2BCD_AUTO_CONVERT_EN
      last_d  = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (go) begin
               shift_d = num;
               acc_d   = 20'h00000;
               cnt_d   = 4'd0;
               busy_d  = 1'b1;
               state_d = SHIFT;
`ifdef BIN2BCD_AUTO_CONVERT_EN
               last_d  = num;
`endif
            end
         end
         SHIFT: begin
            {acc_d, shift_d} = {adj[18:0], shift_q, 1'b0};
            cnt_d = cnt_q + 4'd1;
            // The 16th shift edge publishes the accumulator it is producing.
            if (cnt_q == 4'd15) begin
               bcd_d   = {adj[18:0], shift_q[15]};
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shift_q <= 16'h0000;
         acc_q   <= 20'h00000;
         cnt_q   <= 4'd0;
         bcd_q   <= 20'h00000;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef BIN2BCD_AUTO_CONVERT_EN
         last_q  <= 16'h0000;
`endif
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
`ifdef BIN2BCD_AUTO_CONVERT_EN
         last_q  <= last_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_16bit.sv
// Directed self-checking bench for bin2bcd_16bit (default build, auto-convert macro undefined).
module tb_bin2bcd_16bit;

   logic        clk;
   logic        rst_n;
   logic [15:0] num;
   logic        start;
   logic        busy;
   logic        done;
   logic [19:0] bcd;

   int n_checks = 0;
   int n_pass   = 0;

   bin2bcd_16bit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .num   (num),
      .start (start),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Drive a start at the next edge (E0), optionally poke start/num at E5, then
   // follow the conversion to its done pulse. Called at a negedge.
   task automatic run_conv(input string tag, input logic [15:0] value,
                           input logic [19:0] exp_bcd, input logic [15:0] disturb);
      logic [19:0] bcd_before;
      int cyc, busy_cnt, overlap, early;
      bit seen;
      cyc = 0; busy_cnt = 0; overlap = 0; early = 0; seen = 1'b0;
      num   = value;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start      = 1'b0;
      bcd_before = bcd;
      check({tag, "_busy_e0"}, {19'd0, busy}, 20'd1);
      if (busy) busy_cnt++;
      while (!seen && cyc < 40) begin
         if (cyc == 4) begin
            num   = disturb;
            start = 1'b1;
         end else if (cyc == 5) begin
            start = 1'b0;
         end
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (busy) busy_cnt++;
         if (busy && done) overlap++;
         if (done) seen = 1'b1;
         else if (bcd !== bcd_before) early++;
      end
      check({tag, "_done_seen"}, {19'd0, seen}, 20'd1);
      check({tag, "_latency"}, 20'(cyc), 20'd16);
      check({tag, "_busy_cycles"}, 20'(busy_cnt), 20'd16);
      check({tag, "_busy_done_overlap"}, 20'(overlap), 20'd0);
      check({tag, "_bcd_early_change"}, 20'(early), 20'd0);
      check({tag, "_bcd"}, bcd, exp_bcd);
      @(posedge clk);
      @(negedge clk);
      check({tag, "_done_fall"}, {19'd0, done}, 20'd0);
      check({tag, "_no_queued_start"}, {19'd0, busy}, 20'd0);
      check({tag, "_bcd_hold"}, bcd, exp_bcd);
   endtask

   initial begin
      int done_cnt, first_e, second_e;
      rst_n = 1'b0;
      start = 1'b0;
      num   = 16'd0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("reset_bcd", bcd, 20'h00000);
      check("reset_busy", {19'd0, busy}, 20'd0);
      check("reset_done", {19'd0, done}, 20'd0);

      run_conv("v1234",  16'd1234,  20'h01234, 16'd4321);
      run_conv("v0",     16'd0,     20'h00000, 16'd9);
      run_conv("v65535", 16'd65535, 20'h65535, 16'd1);
      run_conv("v9999",  16'd9999,  20'h09999, 16'd10000);
      run_conv("v10000", 16'd10000, 20'h10000, 16'd55555);
      run_conv("v59999", 16'd59999, 20'h59999, 16'd0);
      run_conv("v100",   16'd100,   20'h00100, 16'd500);

      // start held high for 40 edges: results at E16 and E33
      done_cnt = 0; first_e = -1; second_e = -1;
      num   = 16'd999;
      start = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            done_cnt++;
            if (first_e < 0) first_e = i;
            else if (second_e < 0) second_e = i;
            check("held_bcd", bcd, 20'h00999);
         end
      end
      start = 1'b0;
      check("held_done_count", 20'(done_cnt), 20'd2);
      check("held_first_edge", 20'(first_e), 20'd16);
      check("held_second_edge", 20'(second_e), 20'd33);
      for (int i = 0; i < 20 && busy; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
      @(posedge clk);
      @(negedge clk);
      check("held_drain_idle", {19'd0, busy}, 20'd0);

      // reset in the middle of a conversion aborts it
      num   = 16'd42;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int i = 1; i < 8; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst_n = 1'b0;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_busy", {19'd0, busy}, 20'd0);
      check("abort_bcd", bcd, 20'h00000);
      rst_n = 1'b1;
      start = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) done_cnt++;
      end
      check("abort_no_done", 20'(done_cnt), 20'd0);
      check("abort_bcd_stays", bcd, 20'h00000);
      run_conv("v7", 16'd7, 20'h00007, 16'd3);

      // free-running upstream counter with start low: no conversions
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         num = num + 16'd1;
         @(posedge clk);
         @(negedge clk);
         if (done || busy) done_cnt++;
      end
      check("free_run_no_done", 20'(done_cnt), 20'd0);
      check("free_run_bcd_hold", bcd, 20'h00007);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bin2bcd_16bit.md
BIN2BCD_16BIT -- requirements
Module: bin2bcd_16bit

Interface
REQ-001 Parameters: none; the input width is fixed at 16 bits and the output at 5 BCD digits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 num  input  16  unsigned binary value from the upstream 16-bit counter.
REQ-005 start  input  1  conversion request, level-sampled on rising clk.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  one-cycle pulse when bcd holds a new result.
REQ-008 bcd  output  20  five packed BCD digits: [19:16] ten-thousands ... [3:0] units.

Function
REQ-009 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-010 In IDLE with start=1 at an edge, the block SHALL capture num into the shift register, clear the 20-bit digit accumulator and iteration count, and enter SHIFT.
REQ-011 Each SHIFT edge SHALL do the following:
- add 3 to every accumulator digit >= 5;
- then shift the {accumulator, shift register} pair left by 1;
- increment the iteration count.
REQ-012 On the 16th SHIFT edge, the block SHALL load bcd with the final accumulator value, set done=1 and return to IDLE.
REQ-013 Latency SHALL be 16 cycles: start sampled at edge E0, then bcd valid and done=1 after edge E16; done SHALL fall after E17.
REQ-014 busy SHALL be 1 after edges E0..E15 and 0 after E16; busy and done SHALL never be high together.
REQ-015 start while busy=1 SHALL be ignored, with no queuing; changes on num during SHIFT SHALL NOT affect the result.
REQ-016 start=1 at E17, while done is high, SHALL be accepted; back-to-back throughput is one result per 17 cycles.
REQ-017 bcd SHALL hold its last result between conversions and SHALL change only on the done edge, never with partial values.
REQ-018 Every input 0..65535 SHALL produce the exact decimal digits; the digit-correction adders SHALL be 4 bits wide, with no carry between digits.

Reset
REQ-019 rst_n=0 at an edge SHALL force the following, regardless of state:
- state=IDLE, busy=0, done=0, bcd=20'h00000;
- shift register, accumulator and count cleared.
REQ-020 Reset during SHIFT SHALL abort the conversion with no done pulse; the first start after rst_n returns high SHALL behave as from power-up.
REQ-021 start is ignored on any edge where rst_n=0.

Configuration
REQ-022 Macro BIN2BCD_AUTO_CONVERT_EN defined: in IDLE, the block SHALL also begin a conversion whenever num differs from the last captured value, the same as start=1.
- The last captured value resets to 16'h0000.
- start keeps its normal function.
REQ-023 Macro undefined: conversions SHALL begin only on start, and the last-captured register SHALL NOT exist.

Verification
REQ-024 rst_n=0 for 2 edges, then high -> bcd=20'h00000, busy=0, done=0 before any start.
REQ-025 num=16'd1234, start pulse at E0 -> busy high for 16 cycles, done after E16, bcd=20'h01234; num=0 -> 20'h00000; num=65535 -> 20'h65535.
REQ-026 num=16'd999, start held high for 40 cycles -> results at E16 and E33 (both 20'h00999), done low otherwise.
REQ-027 start at E0 with num=42, rst_n=0 at E8 -> no done pulse, bcd stays 20'h00000; new start with num=7 -> bcd=20'h00007 16 cycles later.
REQ-028 start pulse at E0 with num=100, then start again at E5 with num=500 -> single done at E16 with bcd=20'h00100.
REQ-029 With BIN2BCD_AUTO_CONVERT_EN, free-running upstream counter, start=0 -> one done per 17 cycles, each bcd equal to the decimal num captured 16 cycles earlier; without the macro -> no done ever.
